// File: rtl/mfe_ctrl.sv
// mfe_ctrl: sequencing controller for the multimedia file encryption datapath.
// Builds the cipher key from keyboard characters and loads it into the core.
// Then streams a host-specified number of blocks through the core using
// valid/ready handshakes on the source and sink sides.
module mfe_ctrl #(
    parameter int unsigned KEY_CHARS  = 8,
    parameter int unsigned BLK_W      = 128,
    parameter int unsigned LEN_W      = 16,
    parameter logic [15:0] ENTER_CODE = 16'h005A,
    parameter logic [15:0] ESC_CODE   = 16'h0076
) (
    input  logic                    clk,
    input  logic                    rst,
    // keyboard side
    input  logic [15:0]             char_i,
    input  logic                    char_valid_i,
    // host control
    input  logic                    start_i,
    input  logic [LEN_W-1:0]        num_blocks_i,
    // key to core
    output logic [KEY_CHARS*16-1:0] key_o,
    output logic                    key_load_o,
    // block source
    input  logic [BLK_W-1:0]        in_data_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    // cipher core
    output logic [BLK_W-1:0]        core_data_o,
    output logic                    core_start_o,
    input  logic                    core_done_i,
    input  logic [BLK_W-1:0]        core_result_i,
    // block sink
    output logic [BLK_W-1:0]        out_data_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    // status
    output logic [LEN_W-1:0]        blk_count_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    key_ready_o
);

    localparam int unsigned KEY_W = KEY_CHARS * 16;
    localparam int unsigned CNT_W = $clog2(KEY_CHARS + 1);
    localparam logic [CNT_W-1:0] CntFull = CNT_W'(KEY_CHARS);

    typedef enum logic [2:0] {
        StKeyEntry,
        StKeyLoad,
        StWaitStart,
        StFetch,
        StRun,
        StEmit,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic [BLK_W-1:0]   core_data_q, core_data_d;
    logic [BLK_W-1:0]   out_data_q, out_data_d;
    // Set on entry to RUN so core_start_o fires on the first RUN cycle only.
    logic               start_pend_q, start_pend_d;

    logic               is_esc;
    logic               is_enter;
    logic               is_ord;
    logic [LEN_W-1:0]   blk_cnt_inc;

    assign is_esc      = char_valid_i && (char_i == ESC_CODE);
    assign is_enter    = char_valid_i && (char_i == ENTER_CODE);
    assign is_ord      = char_valid_i && !is_esc && !is_enter;
    assign blk_cnt_inc = blk_cnt_q + LEN_W'(1);

    // State and datapath registers; async reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StKeyEntry;
            key_q        <= '0;
            cnt_q        <= '0;
            len_q        <= '0;
            blk_cnt_q    <= '0;
            core_data_q  <= '0;
            out_data_q   <= '0;
            start_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            blk_cnt_q    <= blk_cnt_d;
            core_data_q  <= core_data_d;
            out_data_q   <= out_data_d;
            start_pend_q <= start_pend_d;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        blk_cnt_d    = blk_cnt_q;
        core_data_d  = core_data_q;
        out_data_d   = out_data_q;
        start_pend_d = 1'b0;

        unique case (state_q)
            StKeyEntry: begin
                if (is_esc) begin
                    key_d = '0;
                    cnt_d = '0;
                end else if (is_enter) begin
                    // A short key is ignored; keep collecting characters.
                    if (cnt_q == CntFull) begin
                        state_d = StKeyLoad;
                    end
                end else if (is_ord && (cnt_q < CntFull)) begin
                    key_d = {key_q[KEY_W-17:0], char_i};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StKeyLoad: begin
                state_d = StWaitStart;
            end

            StWaitStart, StDone: begin
                // ESC wins over a simultaneous start.
                if (is_esc) begin
                    state_d = StKeyEntry;
                    key_d   = '0;
                    cnt_d   = '0;
                end else if (start_i) begin
                    len_d     = num_blocks_i;
                    blk_cnt_d = '0;
                    state_d   = (num_blocks_i == '0) ? StDone : StFetch;
                end
            end

            StFetch: begin
                if (in_valid_i) begin
                    core_data_d  = in_data_i;
                    start_pend_d = 1'b1;
                    state_d      = StRun;
                end
            end

            StRun: begin
                if (core_done_i) begin
                    out_data_d = core_result_i;
                    state_d    = StEmit;
                end
            end

            StEmit: begin
                if (out_ready_i) begin
                    blk_cnt_d = blk_cnt_inc;
                    state_d   = (blk_cnt_inc == len_q) ? StDone : StFetch;
                end
            end

            default: begin
                state_d = StKeyEntry;
            end
        endcase
    end

    // Outputs decoded from the registered state only.
    always_comb begin
        key_load_o   = (state_q == StKeyLoad);
        in_ready_o   = (state_q == StFetch);
        core_start_o = (state_q == StRun) && start_pend_q;
        out_valid_o  = (state_q == StEmit);
        busy_o       = (state_q == StFetch) || (state_q == StRun) || (state_q == StEmit);
        done_o       = (state_q == StDone);
        key_ready_o  = (state_q != StKeyEntry) && (state_q != StKeyLoad);
    end

    assign key_o       = key_q;
    assign core_data_o = core_data_q;
    assign out_data_o  = out_data_q;
    assign blk_count_o = blk_cnt_q;

endmodule

// File: tb/tb_mfe_ctrl.sv
// Self-checking bench for mfe_ctrl: random keys and blocks against a
// behavioural model (key = first KEY_CHARS typed chars, result = data ^ ones).
module tb_mfe_ctrl;

    localparam int unsigned KEY_CHARS = 8;
    localparam int unsigned BLK_W     = 128;
    localparam int unsigned LEN_W     = 16;
    localparam int unsigned KEY_W     = KEY_CHARS * 16;
    localparam logic [15:0] ENTER     = 16'h005A;
    localparam logic [15:0] ESC       = 16'h0076;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [15:0]       char_i = '0;
    logic              char_valid_i = 1'b0;
    logic              start_i = 1'b0;
    logic [LEN_W-1:0]  num_blocks_i = '0;
    logic [KEY_W-1:0]  key_o;
    logic              key_load_o;
    logic [BLK_W-1:0]  in_data_i = '0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [BLK_W-1:0]  core_data_o;
    logic              core_start_o;
    logic              core_done_i = 1'b0;
    logic [BLK_W-1:0]  core_result_i = '0;
    logic [BLK_W-1:0]  out_data_o;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic [LEN_W-1:0]  blk_count_o;
    logic              busy_o;
    logic              done_o;
    logic              key_ready_o;

    int n_checks = 0;
    int n_pass   = 0;
    int n_loads  = 0;
    int n_overlap = 0;

    logic [15:0] typed_q[$];

    always #5 clk = ~clk;

    mfe_ctrl #(
        .KEY_CHARS  (KEY_CHARS),
        .BLK_W      (BLK_W),
        .LEN_W      (LEN_W),
        .ENTER_CODE (ENTER),
        .ESC_CODE   (ESC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .char_i        (char_i),
        .char_valid_i  (char_valid_i),
        .start_i       (start_i),
        .num_blocks_i  (num_blocks_i),
        .key_o         (key_o),
        .key_load_o    (key_load_o),
        .in_data_i     (in_data_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .core_data_o   (core_data_o),
        .core_start_o  (core_start_o),
        .core_done_i   (core_done_i),
        .core_result_i (core_result_i),
        .out_data_o    (out_data_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .blk_count_o   (blk_count_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .key_ready_o   (key_ready_o)
    );

    always @(posedge clk) if (key_load_o === 1'b1) n_loads++;
    always @(negedge clk) if (in_ready_o === 1'b1 && out_valid_o === 1'b1) n_overlap++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Key the sink expects: the first KEY_CHARS ordinary characters typed since
    // the last clear, earliest character most significant.
    function automatic logic [KEY_W-1:0] exp_key();
        logic [KEY_W-1:0] k = '0;
        for (int i = 0; i < typed_q.size() && i < KEY_CHARS; i++) begin
            k = (k << 16) | KEY_W'(typed_q[i]);
        end
        return k;
    endfunction

    function automatic logic [15:0] rand_char();
        logic [15:0] c;
        do c = 16'($urandom_range(1, 16'hFFFF)); while (c == ENTER || c == ESC);
        return c;
    endfunction

    function automatic logic [BLK_W-1:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_char(input logic [15:0] c);
        char_i       = c;
        char_valid_i = 1'b1;
        tick();
        char_valid_i = 1'b0;
        char_i       = rand_char();
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (|{key_o, key_load_o, in_ready_o, core_data_o, core_start_o, out_data_o, out_valid_o,
              blk_count_o, busy_o, done_o, key_ready_o} !== 1'b0)
            $display("FAIL reset_outputs: some output nonzero, key=%h blk=%0d busy=%b",
                     key_o, blk_count_o, busy_o);
        else n_pass++;
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (key_ready_o !== 1'b0 || key_o !== '0)
            $display("FAIL reset_state: key_ready=%b key=%h required 0/0", key_ready_o, key_o);
        else n_pass++;
    endtask

    task automatic test_key_basic();
        typed_q.delete();
        for (int i = 1; i <= 8; i++) begin
            send_char(16'(i));
            typed_q.push_back(16'(i));
        end
        send_char(ENTER);
        n_checks++;
        if (key_load_o !== 1'b1 || key_ready_o !== 1'b0)
            $display("FAIL key_load_pulse: load=%b ready=%b required 1/0", key_load_o, key_ready_o);
        else n_pass++;
        n_checks++;
        if (key_o !== 128'h0001_0002_0003_0004_0005_0006_0007_0008 || key_o !== exp_key())
            $display("FAIL key_value: got %h required %h", key_o, exp_key());
        else n_pass++;
        tick();
        n_checks++;
        if (key_load_o !== 1'b0 || key_ready_o !== 1'b1)
            $display("FAIL key_ready: load=%b ready=%b required 0/1", key_load_o, key_ready_o);
        else n_pass++;
    endtask

    task automatic test_short_and_esc();
        int loads0;
        send_char(ESC);
        typed_q.delete();
        n_checks++;
        if (key_ready_o !== 1'b0 || key_o !== '0)
            $display("FAIL esc_wait: ready=%b key=%h required 0/0", key_ready_o, key_o);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            logic [15:0] c = rand_char();
            send_char(c);
            typed_q.push_back(c);
        end
        loads0 = n_loads;
        send_char(ENTER);
        tick();
        tick();
        n_checks++;
        if (n_loads != loads0 || key_ready_o !== 1'b0 || key_o !== exp_key())
            $display("FAIL short_key: loads=%0d/%0d ready=%b key=%h required %h",
                     n_loads, loads0, key_ready_o, key_o, exp_key());
        else n_pass++;
        send_char(ESC);
        typed_q.delete();
        n_checks++;
        if (key_o !== '0) $display("FAIL esc_clear: key=%h required 0", key_o);
        else n_pass++;
        // Ten characters: the last two must be dropped.
        for (int i = 0; i < 10; i++) begin
            logic [15:0] c = rand_char();
            send_char(c);
            typed_q.push_back(c);
        end
        send_char(ENTER);
        n_checks++;
        if (key_load_o !== 1'b1 || key_o !== exp_key())
            $display("FAIL new_key: load=%b key=%h required 1/%h", key_load_o, key_o, exp_key());
        else n_pass++;
        tick();
    endtask

    // Run n blocks; block long_blk gets a 10-cycle stall with a stray core_done
    // and an ESC strobe, both of which must be ignored.
    task automatic run_blocks(input int n, input int long_blk);
        int loads0 = n_loads;
        logic [KEY_W-1:0] k0 = exp_key();
        start_i      = 1'b1;
        num_blocks_i = LEN_W'(n);
        tick();
        start_i      = 1'b0;
        num_blocks_i = LEN_W'($urandom);
        if (n == 0) begin
            n_checks++;
            if (done_o !== 1'b1 || busy_o !== 1'b0 || blk_count_o !== '0)
                $display("FAIL zero_len: done=%b busy=%b cnt=%0d required 1/0/0",
                         done_o, busy_o, blk_count_o);
            else n_pass++;
        end
        for (int b = 0; b < n; b++) begin
            logic [BLK_W-1:0] d = rand_blk();
            logic [BLK_W-1:0] r = d ^ {BLK_W{1'b1}};
            int hold = (b == long_blk) ? 10 : int'($urandom_range(0, 2));
            n_checks++;
            if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || blk_count_o !== LEN_W'(b))
                $display("FAIL fetch_%0d: in_ready=%b out_valid=%b cnt=%0d required 1/0/%0d",
                         b, in_ready_o, out_valid_o, blk_count_o, b);
            else n_pass++;
            repeat ($urandom_range(0, 2)) tick();
            in_data_i  = d;
            in_valid_i = 1'b1;
            tick();
            in_valid_i = 1'b0;
            in_data_i  = rand_blk();
            n_checks++;
            if (core_start_o !== 1'b1 || core_data_o !== d || in_ready_o !== 1'b0)
                $display("FAIL core_start_%0d: start=%b data=%h required 1/%h",
                         b, core_start_o, core_data_o, d);
            else n_pass++;
            tick();
            n_checks++;
            if (core_start_o !== 1'b0)
                $display("FAIL start_once_%0d: start=%b required 0", b, core_start_o);
            else n_pass++;
            tick();
            tick();
            core_done_i   = 1'b1;
            core_result_i = r;
            tick();
            core_done_i   = 1'b0;
            core_result_i = rand_blk();
            for (int h = 0; h < hold; h++) begin
                n_checks++;
                if (out_valid_o !== 1'b1 || out_data_o !== r || in_ready_o !== 1'b0)
                    $display("FAIL emit_%0d_%0d: valid=%b data=%h required 1/%h",
                             b, h, out_valid_o, out_data_o, r);
                else n_pass++;
                if (b == long_blk && h == 3) core_done_i = 1'b1;
                if (b == long_blk && h == 5) begin
                    char_i       = ESC;
                    char_valid_i = 1'b1;
                end
                tick();
                core_done_i  = 1'b0;
                char_valid_i = 1'b0;
            end
            n_checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== r || key_o !== k0)
                $display("FAIL emit_final_%0d: valid=%b data=%h key=%h required 1/%h/%h",
                         b, out_valid_o, out_data_o, key_o, r, k0);
            else n_pass++;
            out_ready_i = 1'b1;
            tick();
            out_ready_i = 1'b0;
            n_checks++;
            if (blk_count_o !== LEN_W'(b + 1) || out_valid_o !== 1'b0 ||
                done_o !== (b == n - 1) || busy_o !== (b != n - 1))
                $display("FAIL after_emit_%0d: cnt=%0d valid=%b done=%b busy=%b required %0d/0/%b",
                         b, blk_count_o, out_valid_o, done_o, busy_o, b + 1, (b == n - 1));
            else n_pass++;
        end
        n_checks++;
        if (n_loads != loads0 || n_overlap != 0)
            $display("FAIL run_side: key_loads=%0d required %0d, ready/valid overlaps=%0d required 0",
                     n_loads, loads0, n_overlap);
        else n_pass++;
    endtask

    task automatic test_run_three();
        run_blocks(3, 1);
    endtask

    task automatic test_zero_then_one();
        run_blocks(0, -1);
        tick();
        run_blocks(1, -1);
    endtask

    task automatic test_random_runs();
        for (int i = 0; i < 3; i++) run_blocks(int'($urandom_range(1, 4)), -1);
    endtask

    task automatic test_esc_priority();
        start_i      = 1'b1;
        num_blocks_i = 16'd2;
        char_i       = ESC;
        char_valid_i = 1'b1;
        tick();
        start_i      = 1'b0;
        char_valid_i = 1'b0;
        typed_q.delete();
        n_checks++;
        if (key_ready_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || key_o !== '0)
            $display("FAIL esc_priority: ready=%b busy=%b done=%b key=%h required 0/0/0/0",
                     key_ready_o, busy_o, done_o, key_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < KEY_CHARS; i++) begin
            logic [15:0] c = rand_char();
            send_char(c);
            typed_q.push_back(c);
        end
        send_char(ENTER);
        tick();
        start_i      = 1'b1;
        num_blocks_i = 16'd1;
        tick();
        start_i      = 1'b0;
        in_data_i    = rand_blk();
        in_valid_i   = 1'b1;
        tick();
        in_valid_i   = 1'b0;
        n_checks++;
        if (core_start_o !== 1'b1 || key_o !== exp_key())
            $display("FAIL pre_reset_run: start=%b key=%h required 1/%h",
                     core_start_o, key_o, exp_key());
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (|{key_o, key_load_o, in_ready_o, core_data_o, core_start_o, out_data_o, out_valid_o,
              blk_count_o, busy_o, done_o, key_ready_o} !== 1'b0)
            $display("FAIL async_reset: key=%h busy=%b start=%b required all 0",
                     key_o, busy_o, core_start_o);
        else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        core_done_i   = 1'b1;
        core_result_i = rand_blk();
        tick();
        core_done_i   = 1'b0;
        tick();
        n_checks++;
        if (out_valid_o !== 1'b0 || out_data_o !== '0 || busy_o !== 1'b0 || key_ready_o !== 1'b0)
            $display("FAIL stray_done_after_reset: valid=%b data=%h busy=%b ready=%b required 0",
                     out_valid_o, out_data_o, busy_o, key_ready_o);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_key_basic();
        test_short_and_esc();
        test_run_three();
        test_zero_then_one();
        test_random_runs();
        test_esc_priority();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
